// File: rtl/voice_mixer_pkg.sv
// Shared audio constants and helpers for the voice path.
//   BITDEPTH / SAMPLEFREQ : sample format and rate of the synth audio chain
//   LEVEL_UNITY           : per-voice level code that means gain 1.0
//   MASTER_SHIFT          : fractional bits of the master volume gain
//   sat_bits()            : clamp a signed value to a signed 'bits'-wide range
package voice_mixer_pkg;
  localparam int BITDEPTH     = 14;
  localparam int SAMPLEFREQ   = 31250;
  localparam int LEVEL_UNITY  = 8;
  localparam int MASTER_SHIFT = 8;
  localparam int LEVEL_SHIFT  = $clog2(LEVEL_UNITY);
  localparam int MIX_SHIFT    = MASTER_SHIFT + LEVEL_SHIFT;

  // Saturate x to [-2^(bits-1), 2^(bits-1)-1].
  function automatic logic signed [31:0] sat_bits(input logic signed [31:0] x,
                                                  input int bits);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction
endpackage

// File: rtl/voice_mixer_level_ramp.sv
// Per-voice level slew: eff_o walks one code per clock toward the target
// (0 when muted, else level_i), so level and mute changes never click.
//   sample_clock : sample-rate clock
//   reset        : synchronous, active-high; eff_o -> 0
//   level_i      : registered target level
//   mute_i       : registered mute, forces target to 0
//   eff_o        : current effective level
module level_ramp #(
  parameter int LEVELBITS = 4
) (
  input  logic                 sample_clock,
  input  logic                 reset,
  input  logic [LEVELBITS-1:0] level_i,
  input  logic                 mute_i,
  output logic [LEVELBITS-1:0] eff_o
);
  logic [LEVELBITS-1:0] eff_q, eff_d, target;

  always_comb begin
    target = mute_i ? '0 : level_i;
    eff_d  = eff_q;
    if (eff_q < target)      eff_d = eff_q + LEVELBITS'(1);
    else if (eff_q > target) eff_d = eff_q - LEVELBITS'(1);
  end

  always_ff @(posedge sample_clock) begin
    if (reset) eff_q <= '0;
    else       eff_q <= eff_d;
  end

  assign eff_o = eff_q;
endmodule

// File: rtl/voice_mixer.sv
// Voice mixer: per-voice slewed level, sum, master volume, saturate.
// Pipeline: capture (k) -> level multiply (k+1) -> sum (k+2) -> master/clamp (k+3).
//   sample_clock  : sample-rate clock
//   reset         : synchronous, active-high; clears pipeline, ramps, clip
//   voices_in     : packed signed samples, voice i at [i*BITDEPTH +: BITDEPTH]
//   voice_level   : packed unsigned target levels, gain = level/8
//   voice_mute    : per-voice mute (target level forced to 0)
//   master_volume : master gain = (master_volume+1)/256
//   out           : saturated mixed sample
//   clip          : high on saturation and for CLIP_HOLD-1 clocks after
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int BITDEPTH   = voice_mixer_pkg::BITDEPTH,
  parameter int LEVELBITS  = 4,
  parameter int CLIP_HOLD  = voice_mixer_pkg::SAMPLEFREQ
) (
  input  logic                           sample_clock,
  input  logic                           reset,
  input  logic [NUM_VOICES*BITDEPTH-1:0]  voices_in,
  input  logic [NUM_VOICES*LEVELBITS-1:0] voice_level,
  input  logic [NUM_VOICES-1:0]           voice_mute,
  input  logic [7:0]                      master_volume,
  output logic [BITDEPTH-1:0]             out,
  output logic                            clip
);
  import voice_mixer_pkg::*;

  localparam int PW = BITDEPTH + LEVELBITS + 1;          // per-voice product
  localparam int SW = PW + $clog2(NUM_VOICES);           // sum, cannot overflow
  localparam int MW = MASTER_SHIFT + 2;                  // signed (master+1)
  localparam int FW = SW + MW;                           // scaled sum
  localparam int CW = $clog2(CLIP_HOLD + 1);

  // Stage 0
  logic [NUM_VOICES-1:0][BITDEPTH-1:0]  voices_q;
  logic [NUM_VOICES-1:0][LEVELBITS-1:0] level_q;
  logic [NUM_VOICES-1:0]                mute_q;
  logic [7:0]                           mv0_q, mv1_q, mv2_q;
  logic [NUM_VOICES-1:0][LEVELBITS-1:0] eff;

  // Stage 1/2
  logic [NUM_VOICES-1:0][PW-1:0] prod_d, prod_q;
  logic signed [SW-1:0]          sum_d, sum_q;

  // Stage 3
  logic signed [MW-1:0]  mvp;
  logic signed [FW-1:0]  scaled;
  logic signed [31:0]    m32, sat32;
  logic                  clamp;
  logic [BITDEPTH-1:0]   out_d, out_q;
  logic [CW-1:0]         cnt_d, cnt_q;
  logic                  clip_d, clip_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    logic signed [PW-1:0] p;

    level_ramp #(.LEVELBITS(LEVELBITS)) u_ramp (
      .sample_clock (sample_clock),
      .reset        (reset),
      .level_i      (level_q[g]),
      .mute_i       (mute_q[g]),
      .eff_o        (eff[g])
    );

    // Level is unsigned; the zero pad keeps level 15 positive.
    assign p = PW'($signed(voices_q[g])) * PW'($signed({1'b0, eff[g]}));
    assign prod_d[g] = p;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      sum_d = sum_d + SW'($signed(prod_q[i]));
  end

  always_comb begin
    mvp    = $signed({2'b00, mv2_q}) + MW'(1);
    // >>> floors toward -inf, so -1 stays -1 and +1 becomes 0.
    scaled = (FW'(sum_q) * FW'(mvp)) >>> MIX_SHIFT;
    m32    = 32'(scaled);
    sat32  = sat_bits(m32, BITDEPTH);
    clamp  = (sat32 != m32);
    out_d  = sat32[BITDEPTH-1:0];
    clip_d = clamp || (cnt_q != '0);
    cnt_d  = cnt_q;
    if (clamp)              cnt_d = CW'(CLIP_HOLD - 1);
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge sample_clock) begin
    if (reset) begin
      voices_q <= '0;
      level_q  <= '0;
      mute_q   <= '0;
      mv0_q    <= '0;
      mv1_q    <= '0;
      mv2_q    <= '0;
      prod_q   <= '0;
      sum_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      clip_q   <= 1'b0;
    end else begin
      voices_q <= voices_in;
      level_q  <= voice_level;
      mute_q   <= voice_mute;
      mv0_q    <= master_volume;
      mv1_q    <= mv0_q;
      mv2_q    <= mv1_q;
      prod_q   <= prod_d;
      sum_q    <= sum_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      clip_q   <= clip_d;
    end
  end

  assign out  = out_q;
  assign clip = clip_q;
endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;
  localparam int NV   = 4;
  localparam int BD   = 14;
  localparam int LB   = 4;
  localparam int HOLD = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int  v_in[NV];
  int  l_in[NV];
  bit  m_in[NV];
  int  mv_in;

  logic [NV*BD-1:0] vin_w;
  logic [NV*LB-1:0] lvl_w;
  logic [NV-1:0]    mute_w;
  logic [7:0]       mv_w;
  logic signed [BD-1:0] out_w;
  logic             clip_w;

  always_comb begin
    for (int i = 0; i < NV; i++) begin
      vin_w[i*BD +: BD] = v_in[i][BD-1:0];
      lvl_w[i*LB +: LB] = l_in[i][LB-1:0];
      mute_w[i]         = m_in[i];
    end
    mv_w = mv_in[7:0];
  end

  voice_mixer #(.NUM_VOICES(NV), .BITDEPTH(BD), .LEVELBITS(LB), .CLIP_HOLD(HOLD)) dut (
    .sample_clock  (clk),
    .reset         (rst),
    .voices_in     (vin_w),
    .voice_level   (lvl_w),
    .voice_mute    (mute_w),
    .master_volume (mv_w),
    .out           (out_w),
    .clip          (clip_w)
  );

  // Reference model: out after edge n is the mix of the samples captured at
  // edge n-3 weighted by the levels in effect after that same edge.
  typedef struct { int v[NV]; int eff[NV]; int mv; } ent_t;
  ent_t hist[$];
  int   eff_m[NV];
  int   cap_lvl[NV];
  bit   cap_mute[NV];
  int   n_edge = 0;
  int   last_clamp = -1000000;
  int   exp_out = 0;
  int   exp_clip = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic ent_t zero_ent();
    ent_t e;
    for (int i = 0; i < NV; i++) begin e.v[i] = 0; e.eff[i] = 0; end
    e.mv = 0;
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(zero_ent());
    for (int i = 0; i < NV; i++) begin eff_m[i] = 0; cap_lvl[i] = 0; cap_mute[i] = 0; end
    last_clamp = -1000000;
    exp_out = 0;
    exp_clip = 0;
  endtask

  task automatic model_edge();
    ent_t e, o;
    longint acc, scaled;
    for (int i = 0; i < NV; i++) begin
      int tgt;
      tgt = cap_mute[i] ? 0 : cap_lvl[i];
      if (eff_m[i] < tgt) eff_m[i]++;
      else if (eff_m[i] > tgt) eff_m[i]--;
    end
    for (int i = 0; i < NV; i++) begin
      e.v[i] = v_in[i]; e.eff[i] = eff_m[i];
      cap_lvl[i] = l_in[i]; cap_mute[i] = m_in[i];
    end
    e.mv = mv_in;
    hist.push_back(e);
    o = hist.pop_front();
    acc = 0;
    for (int i = 0; i < NV; i++) acc += longint'(o.v[i]) * o.eff[i];
    scaled = (acc * (o.mv + 1)) >>> 11;
    if (scaled > 8191)       begin exp_out = 8191;  last_clamp = n_edge; end
    else if (scaled < -8192) begin exp_out = -8192; last_clamp = n_edge; end
    else                      exp_out = int'(scaled);
    exp_clip = ((n_edge - last_clamp) < HOLD) ? 1 : 0;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n_edge++;
    if (rst) model_reset(); else model_edge();
    #1;
    check("out", out_w, exp_out);
    check("clip", clip_w, exp_clip);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_all(input int v, input int l);
    for (int i = 0; i < NV; i++) begin v_in[i] = v; l_in[i] = l; m_in[i] = 0; end
  endtask

  initial begin
    set_all(0, 0);
    mv_in = 255;
    rst = 1'b1;
    run(2);
    check("reset_out", out_w, 0);
    check("reset_clip", clip_w, 0);
    rst = 1'b0;

    // Unity gain fade-in on voice 0.
    v_in[0] = 1000; l_in[0] = 8;
    run(14);
    check("unity_settle", out_w, 1000);

    // Mute, then unmute after 3 ramp steps.
    m_in[0] = 1;
    run(4);
    m_in[0] = 0;
    run(12);
    check("unmute_settle", out_w, 1000);

    // Rounding of floor shift.
    v_in[0] = -1; l_in[0] = 1;
    run(12);
    check("round_neg1", out_w, -1);
    v_in[0] = 1;
    run(5);
    check("round_pos1", out_w, 0);
    v_in[0] = 1000; l_in[0] = 8; mv_in = 127;
    run(12);
    check("half_master", out_w, 500);
    mv_in = 255;

    // Positive saturation and hold.
    set_all(8191, 15);
    run(20);
    check("pos_sat", out_w, 8191);
    check("pos_clip", clip_w, 1);
    set_all(0, 15);
    run(HOLD + 8);
    check("pos_hold_done", clip_w, 0);

    // Negative saturation, then re-saturate midway through hold.
    set_all(-8192, 15);
    run(6);
    check("neg_sat", out_w, -8192);
    set_all(0, 15);
    run(HOLD / 2);
    set_all(-8192, 15);
    run(2);
    set_all(0, 15);
    run(HOLD - 2);
    check("reload_clip_held", clip_w, 1);
    run(12);
    check("reload_done", clip_w, 0);

    // Reset mid-stream while clipping.
    set_all(8191, 15);
    run(6);
    rst = 1'b1;
    tick();
    check("midreset_out", out_w, 0);
    check("midreset_clip", clip_w, 0);
    rst = 1'b0;
    run(20);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NV; i++) begin
        v_in[i] = int'($urandom_range(0, 16383)) - 8192;
        if ($urandom_range(0, 3) == 0) l_in[i] = int'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) m_in[i] = ~m_in[i];
      end
      if ($urandom_range(0, 15) == 0) mv_in = int'($urandom_range(0, 255));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    run(HOLD + 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
